// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode encodings for the universal shift register
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear, stops at MAX
module sat_counter #(
  parameter  int MAX = 8,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          done
);

  logic at_max;

  assign at_max = (cnt == CW'(MAX));
  assign done   = at_max;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - WIDTH-bit register with clear, load, shift/rotate and shift counter
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter  int               WIDTH     = 8,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             cnt_done
);

  logic [WIDTH-1:0] q_nxt;
  logic             cnt_clr;
  logic             cnt_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else begin
      q <= q_nxt;
    end
  end

  // Clear outranks enable; enable gates every mode including load.
  always_comb begin
    q_nxt   = q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (clr) begin
      q_nxt   = RESET_VAL;
      cnt_clr = 1'b1;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_HOLD: q_nxt = q;
        MODE_SHR: begin
          q_nxt   = {(rot ? q[0] : sin_msb), q[WIDTH-1:1]};
          cnt_inc = 1'b1;
        end
        MODE_SHL: begin
          q_nxt   = {q[WIDTH-2:0], (rot ? q[WIDTH-1] : sin_lsb)};
          cnt_inc = 1'b1;
        end
        MODE_LOAD: begin
          q_nxt   = d;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  sat_counter #(
    .MAX (WIDTH)
  ) u_shift_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .cnt     (shift_cnt),
    .done    (cnt_done)
  );

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard bench for univ_shift_reg at WIDTH 8 and WIDTH 5
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       reset_n, en, clr, rot, sin_msb, sin_lsb;
  logic [1:0] mode;
  logic [7:0] d;

  wire [7:0] q8;
  wire       sm8, sl8, done8;
  wire [3:0] cnt8;
  wire [4:0] q5;
  wire       sm5, sl5, done5;
  wire [2:0] cnt5;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .mode(mode), .rot(rot),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .d(d), .q(q8), .sout_msb(sm8),
    .sout_lsb(sl8), .shift_cnt(cnt8), .cnt_done(done8)
  );

  univ_shift_reg #(.WIDTH(5), .RESET_VAL(5'h15)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .mode(mode), .rot(rot),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .d(d[4:0]), .q(q5), .sout_msb(sm5),
    .sout_lsb(sl5), .shift_cnt(cnt5), .cnt_done(done5)
  );

  typedef struct {
    int q;
    int cnt;
  } exp_t;

  exp_t sb8[$];
  exp_t sb5[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m8_q, m8_c, m5_q, m5_c;
  bit   bits_in [8] = '{1, 0, 1, 1, 0, 0, 1, 0};

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Word-level model: the register is an integer, shifts are arithmetic on it.
  task automatic model(input int w, input int rv, inout int mq, inout int mc);
    int mask;
    int x;
    mask = (1 << w) - 1;
    if (!reset_n || clr) begin
      mq = rv;
      mc = 0;
    end else if (en) begin
      if (mode == 2'd1) begin
        x  = rot ? (mq & 1) : int'(sin_msb);
        mq = (mq >> 1) | (x << (w - 1));
        if (mc < w) mc++;
      end else if (mode == 2'd2) begin
        x  = rot ? ((mq >> (w - 1)) & 1) : int'(sin_lsb);
        mq = ((mq << 1) & mask) | x;
        if (mc < w) mc++;
      end else if (mode == 2'd3) begin
        mq = int'(d) & mask;
        mc = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit c, input logic [1:0] m,
                      input bit rt, input bit sm, input bit sl, input logic [7:0] dd);
    @(negedge clk);
    reset_n = r; en = e; clr = c; mode = m; rot = rt; sin_msb = sm; sin_lsb = sl; d = dd;
    model(8, 'h00, m8_q, m8_c);
    model(5, 'h15, m5_q, m5_c);
    sb8.push_back('{m8_q, m8_c});
    sb5.push_back('{m5_q, m5_c});
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb8.size() > 0) begin
      exp_t e;
      e = sb8.pop_front();
      chk("q8", int'(q8), e.q);
      chk("shift_cnt8", int'(cnt8), e.cnt);
      chk("cnt_done8", int'(done8), int'(e.cnt == 8));
      chk("sout_msb8", int'(sm8), (e.q >> 7) & 1);
      chk("sout_lsb8", int'(sl8), e.q & 1);
    end
    if (sb5.size() > 0) begin
      exp_t e;
      e = sb5.pop_front();
      chk("q5", int'(q5), e.q);
      chk("shift_cnt5", int'(cnt5), e.cnt);
      chk("cnt_done5", int'(done5), int'(e.cnt == 5));
      chk("sout_msb5", int'(sm5), (e.q >> 4) & 1);
      chk("sout_lsb5", int'(sl5), e.q & 1);
    end
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'd0; rot = 1'b0;
    sin_msb = 1'b0; sin_lsb = 1'b0; d = 8'h00;
    m8_q = 0; m8_c = 0; m5_q = 'h15; m5_c = 0;

    step(0, 0, 0, 2'd0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 2'd0, 0, 0, 0, 8'h00);

    // asynchronous reset in the middle of a clock period
    step(1, 1, 0, 2'd3, 0, 0, 0, 8'hA5);
    @(posedge clk);
    #2;
    chk("pre_reset_q8", int'(q8), 'hA5);
    #1;
    reset_n = 1'b0;
    m8_q = 0; m8_c = 0; m5_q = 'h15; m5_c = 0;
    #1;
    chk("async_reset_q8", int'(q8), 'h00);
    chk("async_reset_cnt8", int'(cnt8), 0);
    chk("async_reset_done8", int'(done8), 0);
    chk("async_reset_q5", int'(q5), 'h15);
    step(0, 1, 0, 2'd1, 0, 1, 1, 8'h00);

    step(1, 1, 0, 2'd3, 0, 0, 0, 8'h3C);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 2'd1, 0, 1, 1, 8'h00);
    settle();
    chk("load_hold_q8", int'(q8), 'h3C);
    chk("load_hold_cnt8", int'(cnt8), 0);

    step(1, 1, 1, 2'd0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 2'd2, 0, 0, bits_in[i], 8'h00);
    settle();
    chk("serial_in_q8", int'(q8), 'hB2);
    chk("serial_in_cnt8", int'(cnt8), 8);
    chk("serial_in_done8", int'(done8), 1);
    step(1, 1, 0, 2'd2, 0, 0, 1, 8'h00);
    settle();
    chk("saturate_cnt8", int'(cnt8), 8);

    step(1, 1, 0, 2'd3, 0, 0, 0, 8'h81);
    step(1, 1, 0, 2'd1, 1, 0, 0, 8'h00);
    settle();
    chk("rotate1_q8", int'(q8), 'hC0);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 2'd1, 1, 0, 0, 8'h00);
    settle();
    chk("rotate8_q8", int'(q8), 'h81);
    chk("rotate8_done8", int'(done8), 1);

    step(1, 1, 1, 2'd3, 0, 0, 0, 8'hFF);
    settle();
    chk("clr_prio_q8", int'(q8), 'h00);
    chk("clr_prio_cnt8", int'(cnt8), 0);
    step(1, 1, 0, 2'd3, 0, 0, 0, 8'hFF);
    settle();
    chk("load_after_clr_q8", int'(q8), 'hFF);

    step(1, 0, 1, 2'd0, 0, 0, 0, 8'h00);
    settle();
    chk("w5_clear_q5", int'(q5), 'h15);
    chk("w5_clear_lsb5", int'(sl5), 1);
    step(1, 1, 0, 2'd1, 0, 0, 0, 8'h00);
    settle();
    chk("w5_shr1_q5", int'(q5), 'h0A);
    chk("w5_shr1_lsb5", int'(sl5), 0);
    step(1, 1, 0, 2'd1, 0, 0, 0, 8'h00);
    settle();
    chk("w5_shr2_q5", int'(q5), 'h05);
    chk("w5_shr2_lsb5", int'(sl5), 1);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 24) == 0, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    step(1, 0, 0, 2'd0, 0, 0, 0, 8'h00);
    settle();
    chk("scoreboard_drained", sb8.size() + sb5.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
